// File: rtl/bram_rw_tdp_pipe.sv
// Single-clock true-dual-port block RAM with byte-column write enables.
// Supports per-port read-during-write modes, an optional output register and a post-reset clear.
module bram_rw_tdp_pipe #(
  parameter int unsigned NUM_COL      = 4,
  parameter int unsigned COL_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = NUM_COL * COL_WIDTH,
  parameter int unsigned WRITE_MODE_A = 0,
  parameter int unsigned WRITE_MODE_B = 0,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned INIT_CLEAR   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  enaA,
  input  logic [NUM_COL-1:0]    weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic                  doutA_valid,
  input  logic                  enaB,
  input  logic [NUM_COL-1:0]    weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  doutB_valid
);

  typedef enum logic [1:0] {IDLE_RST, CLEAR, READY} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_clr_we;

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  logic                  w_enA, w_enB, w_wrA, w_wrB, w_collide;
  logic [DATA_WIDTH-1:0] w_colA, w_colB, w_mA, w_mB, w_mAc, w_mBc;
  logic [DATA_WIDTH-1:0] w_oldA, w_oldB, w_newA, w_newB, w_rdA, w_rdB;
  logic                  w_updA, w_updB;
  logic [DATA_WIDTH-1:0] r_dout1A, r_dout1B;
  logic                  r_valid1A, r_valid1B;

  // Clear sequencer: the first rst-low cycle already writes address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr_we) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    case (r_state)
      IDLE_RST: begin
        if (INIT_CLEAR != 0) begin
          w_clr_we    = !rst;
          w_state_nxt = (r_cnt == '1) ? READY : CLEAR;
        end else begin
          w_state_nxt = READY;
        end
      end
      CLEAR: begin
        w_clr_we = !rst;
        if (r_cnt == '1) w_state_nxt = READY;
      end
      READY:   w_state_nxt = READY;
      default: w_state_nxt = IDLE_RST;
    endcase
  end

  assign init_done = (r_state == READY);

  assign w_enA     = enaA & init_done;
  assign w_enB     = enaB & init_done;
  assign w_wrA     = w_enA & (|weA);
  assign w_wrB     = w_enB & (|weB);
  assign w_collide = w_wrA & w_wrB & (addrA == addrB);

  genvar g;
  for (g = 0; g < NUM_COL; g++) begin : g_mask
    assign w_colA[g*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{weA[g]}};
    assign w_colB[g*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{weB[g]}};
  end

  assign w_mA  = w_enA ? w_colA : '0;
  assign w_mB  = w_enB ? w_colB : '0;
  assign w_mAc = w_collide ? w_mA : '0;
  assign w_mBc = w_collide ? w_mB : '0;

  assign w_oldA = r_mem[addrA];
  assign w_oldB = r_mem[addrB];

  // On a same-address double write both ports see the same merged word, port A winning shared columns.
  assign w_newA = (w_oldA & ~w_mA & ~w_mBc) | (dinA & w_mA) | (dinB & w_mBc & ~w_mA);
  assign w_newB = (w_oldB & ~w_mB & ~w_mAc) | (dinA & w_mAc) | (dinB & w_mB & ~w_mAc);

  always_ff @(posedge clk) begin
    if (w_clr_we) r_mem[r_cnt] <= '0;
    if (w_wrB)    r_mem[addrB] <= w_newB;
    if (w_wrA)    r_mem[addrA] <= w_newA;
  end

  assign w_updA = w_enA & (~(|weA) | (WRITE_MODE_A != 0));
  assign w_updB = w_enB & (~(|weB) | (WRITE_MODE_B != 0));
  assign w_rdA  = ((|weA) && (WRITE_MODE_A == 2)) ? w_newA : w_oldA;
  assign w_rdB  = ((|weB) && (WRITE_MODE_B == 2)) ? w_newB : w_oldB;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout1A  <= '0;
      r_dout1B  <= '0;
      r_valid1A <= 1'b0;
      r_valid1B <= 1'b0;
    end else begin
      r_valid1A <= w_updA;
      r_valid1B <= w_updB;
      if (w_updA) r_dout1A <= w_rdA;
      if (w_updB) r_dout1B <= w_rdB;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_dout2A, r_dout2B;
    logic                  r_valid2A, r_valid2B;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dout2A  <= '0;
        r_dout2B  <= '0;
        r_valid2A <= 1'b0;
        r_valid2B <= 1'b0;
      end else begin
        r_dout2A  <= r_dout1A;
        r_dout2B  <= r_dout1B;
        r_valid2A <= r_valid1A;
        r_valid2B <= r_valid1B;
      end
    end

    assign doutA       = r_dout2A;
    assign doutB       = r_dout2B;
    assign doutA_valid = r_valid2A;
    assign doutB_valid = r_valid2B;
  end else begin : g_noreg
    assign doutA       = r_dout1A;
    assign doutB       = r_dout1B;
    assign doutA_valid = r_valid1A;
    assign doutB_valid = r_valid1B;
  end

endmodule

// File: tb/tb_bram_rw_tdp_pipe.sv
// Bench for bram_rw_tdp_pipe: two parameterisations driven in lockstep, checked against a word-level model.
module tb_bram_rw_tdp_pipe;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enaA, enaB;
  logic [3:0]  weA, weB, addrA, addrB;
  logic [31:0] dinA, dinB;
  logic [31:0] doutA0, doutB0, doutA1, doutB1;
  logic        vA0, vB0, vA1, vB1, init0, init1;

  always #5 clk = ~clk;

  // dut0: A read_first, B write_first, no output register
  bram_rw_tdp_pipe #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE_A(1),
                     .WRITE_MODE_B(2), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
    .clk(clk), .rst(rst), .init_done(init0),
    .enaA(enaA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA0), .doutA_valid(vA0),
    .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB0), .doutB_valid(vB0));

  // dut1: A write_first, B no_change, output register
  bram_rw_tdp_pipe #(.NUM_COL(4), .COL_WIDTH(8), .ADDR_WIDTH(4), .WRITE_MODE_A(2),
                     .WRITE_MODE_B(0), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
    .clk(clk), .rst(rst), .init_done(init1),
    .enaA(enaA), .weA(weA), .addrA(addrA), .dinA(dinA), .doutA(doutA1), .doutA_valid(vA1),
    .enaB(enaB), .weB(weB), .addrB(addrB), .dinB(dinB), .doutB(doutB1), .doutB_valid(vB1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [DEPTH];
  int          low_cnt = 0;
  bit          live = 0;
  logic [31:0] s1d [2][2];
  logic [31:0] s2d [2][2];
  logic        s1v [2][2];
  logic        s2v [2][2];

  function automatic logic [31:0] cm(input logic [3:0] w);
    return {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  function automatic int mode_of(input int k, input int p);
    if (k == 0) return (p == 0) ? 1 : 2;
    return (p == 0) ? 2 : 0;
  endfunction

  task automatic model_step();
    logic [31:0] oldw [2];
    logic [31:0] neww [2];
    logic [3:0]  a [2];
    logic [3:0]  w [2];
    logic [31:0] d [2];
    logic        e [2];
    bit          ready;
    a[0] = addrA; a[1] = addrB;
    w[0] = weA;   w[1] = weB;
    d[0] = dinA;  d[1] = dinB;
    if (rst) begin
      live    = 1;
      low_cnt = 0;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          s1d[k][p] = '0; s2d[k][p] = '0; s1v[k][p] = 1'b0; s2v[k][p] = 1'b0;
        end
    end else begin
      ready = (low_cnt >= DEPTH);
      if (!ready) begin
        mem_m[low_cnt[3:0]] = '0;
        low_cnt++;
      end
      e[0] = enaA && ready;
      e[1] = enaB && ready;
      oldw[0] = mem_m[a[0]];
      oldw[1] = mem_m[a[1]];
      // B first so that A's columns override on a shared address
      for (int p = 1; p >= 0; p--)
        if (e[p]) mem_m[a[p]] = (mem_m[a[p]] & ~cm(w[p])) | (d[p] & cm(w[p]));
      neww[0] = mem_m[a[0]];
      neww[1] = mem_m[a[1]];
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) begin
          s2d[k][p] = s1d[k][p];
          s2v[k][p] = s1v[k][p];
          if (!e[p]) s1v[k][p] = 1'b0;
          else if (w[p] == 4'h0) begin
            s1d[k][p] = oldw[p]; s1v[k][p] = 1'b1;
          end else begin
            case (mode_of(k, p))
              0:       s1v[k][p] = 1'b0;
              1:       begin s1d[k][p] = oldw[p]; s1v[k][p] = 1'b1; end
              default: begin s1d[k][p] = neww[p]; s1v[k][p] = 1'b1; end
            endcase
          end
        end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [31:0] ad [2][2];
    logic        av [2][2];
    logic        ai [2];
    @(negedge clk);
    if (live) begin
      ad[0][0] = doutA0; ad[0][1] = doutB0; ad[1][0] = doutA1; ad[1][1] = doutB1;
      av[0][0] = vA0;    av[0][1] = vB0;    av[1][0] = vA1;    av[1][1] = vB1;
      ai[0] = init0;     ai[1] = init1;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model init_done dut%0d", k), 32'(ai[k]), 32'(low_cnt >= DEPTH));
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("model dout dut%0d port%0d", k, p), ad[k][p],
              (k == 1) ? s2d[k][p] : s1d[k][p]);
          chk($sformatf("model valid dut%0d port%0d", k, p), 32'(av[k][p]),
              32'((k == 1) ? s2v[k][p] : s1v[k][p]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic setp(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    enaA = ea; weA = wa; addrA = aa; dinA = da;
    enaB = eb; weB = wb; addrB = ab; dinB = db;
  endtask

  task automatic idle();
    setp(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rnd();
    enaA  = ($urandom_range(0, 3) != 0);
    weA   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
    addrA = 4'($urandom_range(0, 15));
    dinA  = $urandom;
    enaB  = ($urandom_range(0, 3) != 0);
    weB   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
    addrB = 4'($urandom_range(0, 15));
    dinB  = $urandom;
  endtask

  task automatic wait_init(input string nm, input bit random_io);
    int n = 0;
    do begin
      if (random_io) rnd();
      step();
      n++;
    end while (!init0 && n < 40);
    chk(nm, 32'(n), 32'd16);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) step();
    rst = 1'b0;
    wait_init("init_done latency after power-on", 1'b0);
    idle();

    // preload all ones, then reset must clear every word
    for (int i = 0; i < DEPTH; i++) begin
      setp(1'b1, 4'hF, 4'(i), 32'hFFFF_FFFF, 1'b0, 4'h0, 4'h0, 32'h0);
      step();
    end
    idle();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_init("init_done latency after clear", 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      setp(1'b1, 4'h0, 4'(i), 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
      step();
      chk($sformatf("cleared word %0d", i), doutA0, 32'h0);
      chk($sformatf("cleared word %0d valid", i), 32'(vA0), 32'd1);
    end
    idle();
    step();

    // read latency, OUT_REG 0 vs 1
    setp(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    idle();
    repeat (2) step();
    setp(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("latency dut0 data", doutA0, 32'hDEAD_BEEF);
    chk("latency dut0 valid", 32'(vA0), 32'd1);
    chk("latency dut1 not yet valid", 32'(vA1), 32'd0);
    idle();
    step();
    chk("latency dut1 data", doutA1, 32'hDEAD_BEEF);
    chk("latency dut1 valid", 32'(vA1), 32'd1);
    chk("latency dut0 pulse ended", 32'(vA0), 32'd0);

    // read-during-write modes on port B
    setp(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    setp(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    step();
    setp(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'b0011, 4'd5, 32'hAABB_CCDD);
    step();
    chk("write_first B data", doutB0, 32'h1122_CCDD);
    chk("write_first B valid", 32'(vB0), 32'd1);
    idle();
    step();
    chk("no_change B holds", doutB1, 32'h1122_3344);
    chk("no_change B valid", 32'(vB1), 32'd0);

    // read-during-write modes on port A
    setp(1'b1, 4'hF, 4'd5, 32'h1122_3344, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    setp(1'b1, 4'b0011, 4'd5, 32'hAABB_CCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("read_first A data", doutA0, 32'h1122_3344);
    chk("read_first A valid", 32'(vA0), 32'd1);
    idle();
    step();
    chk("write_first A data", doutA1, 32'h1122_CCDD);
    chk("write_first A valid", 32'(vA1), 32'd1);

    // same-address double write
    setp(1'b1, 4'hF, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    setp(1'b1, 4'b0011, 4'd7, 32'hAAAA_AAAA, 1'b1, 4'b0110, 4'd7, 32'hBBBB_BBBB);
    step();
    chk("collision write_first B", doutB0, 32'h00BB_AAAA);
    chk("collision read_first A", doutA0, 32'h0);
    setp(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("collision stored word", doutA0, 32'h00BB_AAAA);
    chk("collision write_first A", doutA1, 32'h00BB_AAAA);

    // cross-port read while the other port writes
    setp(1'b1, 4'hF, 4'd9, 32'h77, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    setp(1'b1, 4'h0, 4'd9, 32'h0, 1'b1, 4'hF, 4'd9, 32'h55);
    step();
    chk("cross-port old data", doutA0, 32'h77);
    setp(1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step();
    chk("cross-port new data", doutA0, 32'h55);

    // reset in the middle of a clear, with traffic during the clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) begin
      rnd();
      step();
    end
    rst = 1'b1;
    rnd();
    step();
    rst = 1'b0;
    wait_init("init_done latency after mid-clear reset", 1'b1);

    // random traffic with occasional resets
    repeat (1500) begin
      rnd();
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
